herald_cmd_responder: RTL
=========================

Name: herald_cmd_responder

Overview:
Chip-side responder for the byte-wide host command protocol on the Herald user-project pins. It accepts a framed command from the host (one opcode byte, then four operand bytes) and dispatches it to the MAC or CORDIC engine over a req/ack handshake. It then returns the 32-bit result to the host as four bytes, MSB first. It sits between the top-level pin synchroniser/muxing logic and the arithmetic engines, and is the counterpart of the host-side driver used in the top-level bench.

Parameters:
OPS_BYTES, 4, operand bytes per command; op_a is the first two bytes and op_b the last two, each big-endian.
RES_BYTES, 4, result bytes returned per successful command.
TIMEOUT, 255, cycles to wait for eng_ack before aborting; 8-bit counter.
ERR_BYTE, 8'hEE, single byte returned on any error.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
in_data  in  8  host byte.
in_valid  in  1  host byte valid.
in_ready  out  1  responder can accept a byte; a transfer occurs when in_valid & in_ready.
out_data  out  8  response byte.
out_valid  out  1  response byte valid.
out_ready  in  1  host consumes the byte; a transfer occurs when out_valid & out_ready.
eng_sel  out  2  opcode[1:0]: 00 MAC_ACC, 01 MAC_CLR, 10 CORDIC_ROT, 11 MAC_READ.
eng_op_a  out  16  operand A.
eng_op_b  out  16  operand B.
eng_req  out  1  engine request; level signal, held until ack.
eng_ack  in  1  engine done; eng_result valid in the same cycle.
eng_result  in  32  engine result.
busy  out  1  high in every state except IDLE.
err  out  1  one-cycle pulse on bad opcode or timeout.

Behaviour:
- Reset (async, active-high) values: state=IDLE, in_ready=1, out_valid=0, out_data=0, eng_req=0, eng_sel=0, eng_op_a=0, eng_op_b=0, busy=0, err=0, all counters=0.
- IDLE: in_ready=1. On an accepted byte:
  - If byte[7:2]!=0, go to ERR with err pulsed.
  - Otherwise latch eng_sel=byte[1:0], clear the byte counter, go to GET_OPS.
- GET_OPS: in_ready=1. Each accepted byte shifts into a 32-bit operand register, MSB first. When the OPS_BYTES-th byte is accepted, drive eng_op_a/eng_op_b and go to ISSUE.
- ISSUE: in_ready=0, eng_req=1 starting the cycle after the last operand byte.
  - On eng_ack: capture eng_result, drop eng_req next cycle, go to SEND.
  - If eng_ack is high in the first ISSUE cycle, it is valid.
  - If TIMEOUT cycles pass without ack: drop eng_req, pulse err, go to ERR.
- SEND: out_valid=1 and out_data=result byte (RES_BYTES-1-idx).
  - The byte is held stable while out_ready=0.
  - Each accepted byte increments idx.
  - After the last byte, go to IDLE with in_ready=1 on the following cycle.
- ERR: out_valid=1, out_data=ERR_BYTE. When it is accepted, go to IDLE.
- in_ready=0 in ISSUE, SEND and ERR. Host bytes offered then are not consumed; the host must hold them.
- Minimum latency: 1 cycle from the last operand byte to eng_req; 1 cycle from eng_ack to the first out_valid.
- Full-rate operation: consecutive commands with in_valid and out_ready tied high sustain one byte per cycle, apart from the ISSUE cycles.
- eng_op_a, eng_op_b and eng_sel hold their values until the next command's operands are complete.
- Async reset mid-frame aborts the frame immediately. A pending eng_req drops asynchronously, and partial operands are discarded.

Decomposition:
- Package herald_pkg holds:
  - opcode constants OP_MAC_ACC/OP_MAC_CLR/OP_CORDIC_ROT/OP_MAC_READ;
  - the state enum (IDLE, GET_OPS, ISSUE, SEND, ERR);
  - ERR_BYTE.
- Sub-module herald_byte_serializer: a 32-bit load, byte-wise valid/ready output shifter, used by both SEND and ERR.

Test Plan:
- CORDIC rotation:
  - Stimulus: bytes 02,12,34,AB,CD with an engine model that acks after 3 cycles with 0xDEADBEEF.
  - Required: eng_sel=2, op_a=0x1234, op_b=0xABCD, eng_req high exactly 3 cycles, output DE,AD,BE,EF.
- Back-pressure:
  - Stimulus: MAC_ACC; out_ready low for 5 cycles on the 2nd result byte.
  - Required: out_data stays AD with out_valid=1; no byte lost or repeated.
- Bad opcode:
  - Stimulus: opcode 0x40.
  - Required: err pulses for 1 cycle, single EE byte returned, next frame 03,00,00,00,00 processes normally.
- Timeout:
  - Stimulus: eng_ack never asserted.
  - Required: eng_req drops after 255 cycles, err pulses, EE returned, busy falls after the EE byte is accepted.
- Reset mid-frame:
  - Stimulus: rst asserted after 2 operand bytes, or during ISSUE.
  - Required: all outputs take reset values asynchronously; the following full frame returns the correct result.
- Back-to-back commands:
  - Stimulus: two frames with in_valid/out_ready tied high, engine acks immediately.
  - Required: 8 result bytes in order, no lost or repeated bytes.

Source files
------------

// File: rtl/herald_pkg.sv
// Shared definitions for the Herald host command responder: opcodes, FSM
// states and framing constants.
package herald_pkg;

  localparam logic [1:0] OP_MAC_ACC    = 2'b00;
  localparam logic [1:0] OP_MAC_CLR    = 2'b01;
  localparam logic [1:0] OP_CORDIC_ROT = 2'b10;
  localparam logic [1:0] OP_MAC_READ   = 2'b11;

  localparam int OPS_BYTES = 4;
  localparam int RES_BYTES = 4;
  localparam int TIMEOUT   = 255;

  localparam logic [7:0] ERR_BYTE = 8'hEE;

  // Terminal values of the shared 8-bit counter in GET_OPS and ISSUE.
  localparam logic [7:0] OPS_LAST     = 8'(OPS_BYTES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_OPS = 3'd1,
    ISSUE   = 3'd2,
    SEND    = 3'd3,
    ERR     = 3'd4
  } state_t;

endpackage

// File: rtl/herald_byte_serializer.sv
// Loads up to four bytes as one 32-bit word and emits them MSB first over a
// valid/ready byte stream.
module herald_byte_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_count,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  logic [31:0] shift_reg;
  logic [2:0]  count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      count_reg <= load_count;
    end else if (out_valid && out_ready) begin
      shift_reg <= {shift_reg[23:0], 8'd0};
      count_reg <= count_reg - 3'd1;
    end
  end

  assign out_data  = shift_reg[31:24];
  assign out_valid = (count_reg != 3'd0);
  assign out_last  = (count_reg == 3'd1);

endmodule

// File: rtl/herald_cmd_responder.sv
// Host command responder: takes an opcode plus four operand bytes, runs one
// engine req/ack transaction and returns the 32-bit result or an error byte.
module herald_cmd_responder
  import herald_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  eng_sel,
  output logic [15:0] eng_op_a,
  output logic [15:0] eng_op_b,
  output logic        eng_req,
  input  logic        eng_ack,
  input  logic [31:0] eng_result,
  output logic        busy,
  output logic        err
);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [1:0]  opcode_reg, opcode_next;
  logic [31:0] ops_reg, ops_next;
  logic [1:0]  eng_sel_reg, eng_sel_next;
  logic [15:0] op_a_reg, op_a_next;
  logic [15:0] op_b_reg, op_b_next;
  logic        err_reg, err_next;

  logic        ser_load;
  logic [31:0] ser_data;
  logic [2:0]  ser_count;
  logic        ser_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      opcode_reg  <= '0;
      ops_reg     <= '0;
      eng_sel_reg <= '0;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      opcode_reg  <= opcode_next;
      ops_reg     <= ops_next;
      eng_sel_reg <= eng_sel_next;
      op_a_reg    <= op_a_next;
      op_b_reg    <= op_b_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    opcode_next  = opcode_reg;
    ops_next     = ops_reg;
    eng_sel_next = eng_sel_reg;
    op_a_next    = op_a_reg;
    op_b_next    = op_b_reg;
    err_next     = 1'b0;
    ser_load     = 1'b0;
    ser_data     = '0;
    ser_count    = '0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (in_data[7:2] != 6'd0) begin
            err_next   = 1'b1;
            ser_load   = 1'b1;
            ser_data   = {ERR_BYTE, 24'd0};
            ser_count  = 3'd1;
            state_next = ERR;
          end else begin
            opcode_next = in_data[1:0];
            cnt_next    = '0;
            state_next  = GET_OPS;
          end
        end
      end
      GET_OPS: begin
        if (in_valid) begin
          ops_next = {ops_reg[23:0], in_data};
          if (cnt_reg == OPS_LAST) begin
            // Engine-facing registers only change once a command is complete.
            eng_sel_next = opcode_reg;
            op_a_next    = ops_next[31:16];
            op_b_next    = ops_next[15:0];
            cnt_next     = '0;
            state_next   = ISSUE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      ISSUE: begin
        if (eng_ack) begin
          ser_load   = 1'b1;
          ser_data   = eng_result;
          ser_count  = 3'(RES_BYTES);
          state_next = SEND;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          err_next   = 1'b1;
          ser_load   = 1'b1;
          ser_data   = {ERR_BYTE, 24'd0};
          ser_count  = 3'd1;
          state_next = ERR;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      SEND, ERR: begin
        if (out_valid && out_ready && ser_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  herald_byte_serializer u_serializer (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_data  (ser_data),
    .load_count (ser_count),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (ser_last)
  );

  // Decoded from state so reset drops eng_req without waiting for a clock.
  assign in_ready = (state_reg == IDLE) || (state_reg == GET_OPS);
  assign eng_req  = (state_reg == ISSUE);
  assign busy     = (state_reg != IDLE);
  assign err      = err_reg;
  assign eng_sel  = eng_sel_reg;
  assign eng_op_a = op_a_reg;
  assign eng_op_b = op_b_reg;

endmodule
